// File: rtl/ycrcb422_unpack.sv
// BT.656 4:2:2 byte stream to per-pixel (y, cb, cr) with SAV/EAV lock, coordinates and field flags.
// Outputs registered one clk after the accepted Cr/Y1 byte; no backpressure, data_valid qualifies each byte.
module ycrcb422_unpack #(
   parameter int H_ACTIVE = 720,
   parameter int V_MAX    = 1023
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic [7:0] y,
   output logic [7:0] cb,
   output logic [7:0] cr,
   output logic       pixel_valid,
   output logic [9:0] hcount,
   output logic [9:0] vcount,
   output logic       field,
   output logic       vblank,
   output logic       frame_start
);

   typedef enum logic [2:0] {SEARCH, T1, T2, XY, ACTIVE} state_t;

   state_t     state_q, state_d;
   logic [1:0] phase_q, phase_d;
   logic [7:0] cb_lat_q, cb_lat_d;
   logic [7:0] y0_lat_q, y0_lat_d;
   logic [7:0] cr_lat_q, cr_lat_d;
   logic [9:0] idx_q, idx_d;
   logic [9:0] line_q, line_d;
   logic       emitted_q, emitted_d;

   logic [7:0] y_q, y_d, cb_q, cb_d, cr_q, cr_d;
   logic [9:0] hcount_q, hcount_d, vcount_q, vcount_d;
   logic       pixel_valid_q, pixel_valid_d;
   logic       field_q, field_d, vblank_q, vblank_d;
   logic       frame_start_q, frame_start_d;

   logic       emit;
   logic [7:0] em_y, em_cb, em_cr;

   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      cb_lat_d      = cb_lat_q;
      y0_lat_d      = y0_lat_q;
      cr_lat_d      = cr_lat_q;
      idx_d         = idx_q;
      line_d        = line_q;
      emitted_d     = emitted_q;
      y_d           = y_q;
      cb_d          = cb_q;
      cr_d          = cr_q;
      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      field_d       = field_q;
      vblank_d      = vblank_q;
      pixel_valid_d = 1'b0;
      frame_start_d = 1'b0;
      emit          = 1'b0;
      em_y          = y0_lat_q;
      em_cb         = cb_lat_q;
      em_cr         = cr_lat_q;

      if (data_valid) begin
         case (state_q)
            SEARCH: begin
               if (data_in == 8'hFF) state_d = T1;
            end
            T1: begin
               if (data_in == 8'hFF)      state_d = T1;
               else if (data_in == 8'h00) state_d = T2;
               else                       state_d = SEARCH;
            end
            T2: begin
               if (data_in == 8'hFF)      state_d = T1;
               else if (data_in == 8'h00) state_d = XY;
               else                       state_d = SEARCH;
            end
            XY: begin
               state_d = SEARCH;
               // A code byte without its marker bit is treated as a broken TRS.
               if (data_in[7]) begin
                  field_d  = data_in[6];
                  vblank_d = data_in[5];
                  if (!data_in[4]) begin
                     if (!data_in[5]) begin
                        state_d   = ACTIVE;
                        phase_d   = 2'd0;
                        idx_d     = 10'd0;
                        emitted_d = 1'b0;
                     end
                  end else if (data_in[5]) begin
                     line_d = 10'd0;
                  end else if (emitted_q && (line_q != 10'(V_MAX))) begin
                     line_d = line_q + 10'd1;
                  end
               end
            end
            ACTIVE: begin
               if (data_in == 8'hFF) begin
                  state_d = T1;
               end else begin
                  phase_d = phase_q + 2'd1;
                  case (phase_q)
                     2'd0: cb_lat_d = data_in;
                     2'd1: y0_lat_d = data_in;
                     2'd2: begin
                        cr_lat_d = data_in;
                        emit     = (idx_q < 10'(H_ACTIVE));
                        em_y     = y0_lat_q;
                        em_cr    = data_in;
                     end
                     default: begin
                        emit  = (idx_q < 10'(H_ACTIVE));
                        em_y  = data_in;
                        em_cr = cr_lat_q;
                     end
                  endcase
               end
            end
            default: state_d = SEARCH;
         endcase
      end

      if (emit) begin
         pixel_valid_d = 1'b1;
         y_d           = em_y;
         cb_d          = em_cb;
         cr_d          = em_cr;
         hcount_d      = idx_q;
         vcount_d      = line_q;
         frame_start_d = (idx_q == 10'd0) && (line_q == 10'd0) && !field_q;
         idx_d         = idx_q + 10'd1;
         emitted_d     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= SEARCH;
         phase_q       <= 2'd0;
         cb_lat_q      <= 8'd0;
         y0_lat_q      <= 8'd0;
         cr_lat_q      <= 8'd0;
         idx_q         <= 10'd0;
         line_q        <= 10'd0;
         emitted_q     <= 1'b0;
         y_q           <= 8'd0;
         cb_q          <= 8'd0;
         cr_q          <= 8'd0;
         hcount_q      <= 10'd0;
         vcount_q      <= 10'd0;
         field_q       <= 1'b0;
         vblank_q      <= 1'b0;
         pixel_valid_q <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         cb_lat_q      <= cb_lat_d;
         y0_lat_q      <= y0_lat_d;
         cr_lat_q      <= cr_lat_d;
         idx_q         <= idx_d;
         line_q        <= line_d;
         emitted_q     <= emitted_d;
         y_q           <= y_d;
         cb_q          <= cb_d;
         cr_q          <= cr_d;
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         field_q       <= field_d;
         vblank_q      <= vblank_d;
         pixel_valid_q <= pixel_valid_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign y           = y_q;
   assign cb          = cb_q;
   assign cr          = cr_q;
   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign field       = field_q;
   assign vblank      = vblank_q;
   assign pixel_valid = pixel_valid_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ycrcb422_unpack.sv
// Directed/random BT.656 streams checked against a byte-history reference model.
module tb_ycrcb422_unpack;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       data_valid;
   logic [7:0] y, cb, cr;
   logic       pixel_valid;
   logic [9:0] hcount, vcount;
   logic       field, vblank, frame_start;

   ycrcb422_unpack dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .y(y), .cb(cb), .cr(cr), .pixel_valid(pixel_valid),
      .hcount(hcount), .vcount(vcount), .field(field), .vblank(vblank),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] y, cb, cr;
      logic [9:0] hc, vc;
      logic       fs;
   } pix_t;

   pix_t       exp_q[$];
   pix_t       mon_e;
   int         vectors = 0;
   int         miscompares = 0;
   int         strobes = 0;
   int         fs_cnt = 0;
   int         hc_max = 0;
   logic       last_dv = 1'b0;

   // reference model state: a line is just the list of active bytes since SAV
   bit         locked;
   logic [7:0] lb[$];
   logic [7:0] win[$];
   int         line;
   bit         m_field, m_vblank, emitted;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      locked = 0; lb.delete(); win.delete(); line = 0;
      m_field = 0; m_vblank = 0; emitted = 0; exp_q.delete();
   endtask

   task automatic push_pix(input int pix, input logic [7:0] py, input logic [7:0] pcb, input logic [7:0] pcr);
      pix_t p;
      if (pix < 720) begin
         p.y = py; p.cb = pcb; p.cr = pcr;
         p.hc = 10'(pix); p.vc = 10'(line);
         p.fs = (pix == 0) && (line == 0) && !m_field;
         exp_q.push_back(p);
         emitted = 1;
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      int k;
      if (locked && b != 8'hFF) begin
         lb.push_back(b);
         k = lb.size() - 1;
         if (k % 4 == 2)      push_pix((k / 4) * 2,     lb[k-1], lb[k-2], b);
         else if (k % 4 == 3) push_pix((k / 4) * 2 + 1, b,       lb[k-3], lb[k-1]);
      end else begin
         locked = 0;
         win.push_back(b);
         if (win.size() > 4) void'(win.pop_front());
         if (win.size() == 4 && win[0] == 8'hFF && win[1] == 8'h00 && win[2] == 8'h00) begin
            win.delete();
            if (b[7]) begin
               m_field = b[6]; m_vblank = b[5];
               if (!b[4]) begin
                  if (!b[5]) begin locked = 1; lb.delete(); emitted = 0; end
               end else if (b[5]) line = 0;
               else if (emitted && line < 1023) line++;
            end
         end
      end
   endtask

   task automatic send(input logic [7:0] b, input logic dv);
      data_in = b; data_valid = dv;
      @(posedge clk); #1;
      last_dv = dv;
      if (dv) model_byte(b);
   endtask

   task automatic idle(input int n);
      repeat (n) send(8'($urandom_range(0, 255)), 1'b0);
   endtask

   task automatic trs(input logic [7:0] x);
      send(8'hFF, 1); send(8'h00, 1); send(8'h00, 1); send(x, 1);
   endtask

   task automatic samples(input int n);
      repeat (n) send(8'($urandom_range(1, 254)), 1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_y"}, y, 0);           chk({tag, "_cb"}, cb, 0);
      chk({tag, "_cr"}, cr, 0);         chk({tag, "_pv"}, pixel_valid, 0);
      chk({tag, "_hc"}, hcount, 0);     chk({tag, "_vc"}, vcount, 0);
      chk({tag, "_field"}, field, 0);   chk({tag, "_vblank"}, vblank, 0);
      chk({tag, "_fs"}, frame_start, 0);
   endtask

   always @(negedge clk) begin
      if (pixel_valid) begin
         strobes++;
         if (frame_start) fs_cnt++;
         if (int'(hcount) > hc_max) hc_max = int'(hcount);
         chk("pv_after_idle", last_dv, 1);
         if (exp_q.size() == 0) begin
            chk("spurious_strobe", pixel_valid, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("pix_y", y, mon_e.y);           chk("pix_cb", cb, mon_e.cb);
            chk("pix_cr", cr, mon_e.cr);        chk("pix_hcount", hcount, mon_e.hc);
            chk("pix_vcount", vcount, mon_e.vc); chk("pix_frame_start", frame_start, mon_e.fs);
         end
      end else if (frame_start) begin
         chk("fs_without_pv", frame_start, 0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   int s0, f0;
   logic [7:0] t1_bytes[8];

   initial begin
      t1_bytes = '{8'hFF, 8'h00, 8'h00, 8'h80, 8'h10, 8'h50, 8'hF0, 8'h60};
      reset = 1; data_valid = 0; data_in = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      reset = 0;

      // basic SAV and one pixel pair
      s0 = strobes; f0 = fs_cnt;
      for (int i = 0; i < 8; i++) send(t1_bytes[i], 1);
      idle(3);
      chk("t1_strobes", strobes - s0, 2);
      chk("t1_frame_start", fs_cnt - f0, 1);
      chk("t1_field", field, 0);
      chk("t1_vblank", vblank, 0);
      chk("t1_last_y", y, 8'h60);
      chk("t1_last_hc", hcount, 1);
      chk("t1_drain", exp_q.size(), 0);

      // full line then EAV advances the line counter
      s0 = strobes; f0 = fs_cnt; hc_max = 0;
      trs(8'h80); samples(1440); trs(8'h9D); idle(2);
      chk("t2_strobes", strobes - s0, 720);
      chk("t2_frame_start", fs_cnt - f0, 1);
      chk("t2_hmax", hc_max, 719);
      s0 = strobes; f0 = fs_cnt;
      trs(8'h80); samples(8); idle(2);
      chk("t2_next_strobes", strobes - s0, 4);
      chk("t2_next_fs", fs_cnt - f0, 0);
      chk("t2_next_vcount", vcount, 1);
      chk("t2_drain", exp_q.size(), 0);

      // overlong line is truncated at H_ACTIVE
      s0 = strobes; hc_max = 0;
      trs(8'h80); samples(1600); trs(8'h9D); idle(2);
      chk("t3_strobes", strobes - s0, 720);
      chk("t3_hmax", hc_max, 719);
      chk("t3_drain", exp_q.size(), 0);

      // interleaved idle cycles must not change the pixel stream
      s0 = strobes; f0 = fs_cnt;
      for (int i = 0; i < 8; i++) begin
         send(t1_bytes[i], 1);
         send(8'($urandom_range(0, 255)), 0);
      end
      idle(2);
      chk("t4_strobes", strobes - s0, 2);
      chk("t4_fs", fs_cnt - f0, 0);
      chk("t4_y", y, 8'h60);
      chk("t4_cb", cb, 8'h10);
      chk("t4_cr", cr, 8'hF0);
      chk("t4_vcount", vcount, 2);
      chk("t4_drain", exp_q.size(), 0);

      // corrupted timing codes never lock
      s0 = strobes;
      send(8'hFF, 1); send(8'h00, 1); send(8'h12, 1); send(8'h80, 1);
      samples(8);
      trs(8'h00);
      samples(8); idle(2);
      chk("t5_strobes", strobes - s0, 0);
      chk("t5_field", field, 0);
      chk("t5_vblank", vblank, 0);
      s0 = strobes;
      trs(8'h80); samples(8); idle(2);
      chk("t5_relock_strobes", strobes - s0, 4);
      chk("t5_drain", exp_q.size(), 0);

      // vertical blanking codes and field 1
      s0 = strobes; f0 = fs_cnt;
      trs(8'hAB);
      chk("t6_vblank_set", vblank, 1);
      chk("t6_field0", field, 0);
      samples(8);
      trs(8'hB6);
      chk("t6_vblank_eav", vblank, 1);
      chk("t6_blank_strobes", strobes - s0, 0);
      trs(8'hC7);
      chk("t6_field1", field, 1);
      chk("t6_vblank_clr", vblank, 0);
      samples(8); idle(2);
      chk("t6_strobes", strobes - s0, 4);
      chk("t6_fs", fs_cnt - f0, 0);
      chk("t6_vcount", vcount, 0);
      chk("t6_drain", exp_q.size(), 0);

      // reset in the middle of a line
      s0 = strobes;
      trs(8'h80); samples(200); idle(2);
      chk("t7_pre_strobes", strobes - s0, 100);
      reset = 1;
      @(posedge clk); #1;
      check_zero("t7_reset");
      model_reset();
      reset = 0;
      s0 = strobes;
      samples(40); idle(2);
      chk("t7_post_strobes", strobes - s0, 0);
      chk("t7_drain", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
